// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and mask helpers for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Byte-enable pattern for an access at lane 0; callers keep the low XLEN/8 bits.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Lane bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shift / byte enables and load lane extract with extension
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                    size,
    input  logic [$clog2(XLEN/8)-1:0]     lane,
    input  logic                          sgn,
    input  logic [XLEN-1:0]               wdata,
    input  logic [XLEN-1:0]               rdata,
    output logic [XLEN/8-1:0]             be,
    output logic [XLEN-1:0]               wdata_sh,
    output logic [XLEN-1:0]               rdata_ext
);

    localparam int NB = XLEN / 8;

    logic [NB-1:0]   mask;
    logic [XLEN-1:0] shifted;
    logic            msb;
    logic            fill;

    // Store side: move right-aligned data and its enables up to the addressed lane.
    always_comb begin
        mask     = NB'(size_mask(size));
        be       = mask << lane;
        wdata_sh = wdata << {lane, 3'b000};
    end

    // Load side: bring the addressed lane down to bit 0, then fill unused bytes with sign or zero.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (size)
            SZ_B:    msb = shifted[7];
            SZ_H:    msb = shifted[15];
            SZ_W:    msb = shifted[31];
            default: msb = shifted[XLEN-1];
        endcase
        fill      = sgn & msb;
        rdata_ext = '0;
        for (int i = 0; i < NB; i++) begin
            rdata_ext[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : {8{fill}};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit top; LSU_MISALIGN_TRAP_EN selects trap vs force-align on misalignment
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [XLEN-1:0]      req_base,
    input  logic [XLEN-1:0]      req_offset,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int L  = $clog2(NB);

    lsu_state_t state, next_state;

    logic [XLEN-1:0] ea;
    logic [L-1:0]    raw_lane;
    logic [L-1:0]    lmask;
    logic [L-1:0]    lane_in;
    logic            misaligned;
    logic            illegal;
    logic            bad;
    logic            accept;
    logic            unused_ea_hi;

    logic            r_store;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [XLEN-1:0] r_wdata;
    logic [L-1:0]    r_lane;
    logic            r_err;
    logic [1:0]      cnt;

    logic [NB-1:0]   be_sh;
    logic [XLEN-1:0] rdata_ext;

    // Request decode: effective address, lane and error classification.
    always_comb begin
        ea         = req_base + req_offset;
        raw_lane   = ea[L-1:0];
        lmask      = L'(lane_mask(req_size));
        misaligned = |(raw_lane & lmask);
        illegal    = (XLEN == 32) && (req_size == SZ_D);
`ifdef LSU_MISALIGN_TRAP_EN
        bad        = illegal | misaligned;
        lane_in    = raw_lane;
`else
        bad        = illegal;
        lane_in    = raw_lane & ~lmask;
`endif
        accept     = req_valid & req_ready;
    end

    // Address bits above the word index alias onto the same memory.
    assign unused_ea_hi = ^{ea[XLEN-1:ADDR_W+L], misaligned};

    lsu_align #(.XLEN(XLEN)) u_align (
        .size      (r_size),
        .lane      (r_lane),
        .sgn       (r_signed),
        .wdata     (r_wdata),
        .rdata     (mem_rdata),
        .be        (be_sh),
        .wdata_sh  (mem_wdata),
        .rdata_ext (rdata_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = bad ? RESP : ISSUE;
            ISSUE:   next_state = r_store ? RESP : WAIT;
            WAIT:    if (cnt == 2'd0) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) & r_err;
        mem_en    = (state == ISSUE);
        mem_we    = (state == ISSUE) & r_store;
        mem_be    = (state == ISSUE) ? be_sh : '0;
    end

    // Request capture, latency counter and load result register. A rejected
    // request only flags the error so the memory-facing registers keep their value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_store  <= 1'b0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_lane   <= '0;
            r_err    <= 1'b0;
            cnt      <= 2'd0;
            mem_addr <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                r_err    <= bad;
                rsp_data <= '0;
                if (!bad) begin
                    r_store  <= req_store;
                    r_size   <= req_size;
                    r_signed <= req_signed;
                    r_wdata  <= req_wdata;
                    r_lane   <= lane_in;
                    mem_addr <= ea[ADDR_W+L-1:L];
                end
            end
            if (state == ISSUE) begin
                cnt <= 2'(MEM_LAT - 1);
            end else if (state == WAIT) begin
                if (cnt != 2'd0) cnt <= cnt - 2'd1;
                else             rsp_data <= rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-level reference memory
module tb_load_store_unit;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 8;
    localparam int MEM_LAT = 3;
    localparam int MEM_BYTES = (1 << ADDR_W) * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Data memory the unit drives: byte-enabled writes, reads delayed MEM_LAT cycles.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model state: flat byte memory plus expectation queues.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } stb_t;

    logic [7:0] ref_b [0:MEM_BYTES-1];
    rsp_t rsp_q[$];
    stb_t stb_q[$];

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Expected behaviour of one accepted request, derived from byte-level rules.
    task automatic model(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                         input logic use_c, input logic [31:0] c, input int acc);
        logic [31:0] ea;
        logic [63:0] v;
        int n;
        int lane;
        int idx;
        logic err;
        rsp_t r;
        stb_t s;
        ea  = b + o;
        n   = 1 << sz;
        err = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((ea % n) != 0) err = 1'b1;
`else
        if (!err) ea = ea - (ea % n);
`endif
        v = 64'd0;
        if (!err) begin
            lane    = int'(ea % 4);
            idx     = int'(ea % MEM_BYTES);
            s.addr  = 8'((ea % MEM_BYTES) / 4);
            s.we    = st;
            s.be    = 4'(((1 << n) - 1) << lane);
            s.wdata = wd << (8 * lane);
            s.cyc   = acc + 1;
            stb_q.push_back(s);
            for (int i = 0; i < n; i++) begin
                if (st) ref_b[idx + i] = wd[8*i +: 8];
                else    v = v | (64'(ref_b[idx + i]) << (8 * i));
            end
            if (!st && sg && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
        end
        r.data = (err || st) ? 32'd0 : v[31:0];
        if (use_c) r.data = c;
        r.err = err;
        r.cyc = acc + (err ? 1 : (st ? 2 : MEM_LAT + 2));
        rsp_q.push_back(r);
    endtask

    // Present a request at a negedge and return at the negedge after it is accepted.
    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                         input logic use_c, input logic [31:0] c, output int acc);
        int waited;
        waited     = 0;
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_base   = b;
        req_offset = o;
        req_wdata  = wd;
        acc        = -1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
            return;
        end
        acc = ncyc;
        model(st, sz, sg, b, o, wd, use_c, c, acc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every response pulse and memory strobe against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                vectors++;
                if (rsp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp: data=%h err=%0b at cycle %0d, required no response", rsp_data, rsp_err, ncyc);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    if (rsp_data !== e.data || rsp_err !== e.err || ncyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL rsp: data=%h err=%0b cyc=%0d, required data=%h err=%0b cyc=%0d",
                                 rsp_data, rsp_err, ncyc, e.data, e.err, e.cyc);
                    end
                end
            end
            if (mem_en) begin
                vectors++;
                if (stb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_mem_en: addr=%h we=%0b at cycle %0d, required no strobe", mem_addr, mem_we, ncyc);
                end else begin
                    stb_t e;
                    e = stb_q.pop_front();
                    if (mem_addr !== e.addr || mem_we !== e.we || mem_be !== e.be ||
                        mem_wdata !== e.wdata || ncyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL strobe: addr=%h we=%0b be=%b wdata=%h cyc=%0d, required addr=%h we=%0b be=%b wdata=%h cyc=%0d",
                                 mem_addr, mem_we, mem_be, mem_wdata, ncyc, e.addr, e.we, e.be, e.wdata, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    int a0, a1, a2, a3;
    int budget;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) ref_b[i] = 8'd0;
        rst = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {31'd0, req_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_be, mem_addr},
              {31'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        check("reset_data", {mem_wdata, rsp_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store word then load word (ea 0x104 -> word 0x41).
        issue(1, 2'd2, 0, 32'h100, 32'h4, 32'hDEADBEEF, 0, 0, a0);
        idle(3);
        issue(0, 2'd2, 0, 32'h100, 32'h4, 32'h0, 1, 32'hDEADBEEF, a0);
        idle(6);

        // Signed and unsigned byte load from lane 2 of 0x80FF7F01.
        issue(1, 2'd2, 0, 32'h40, 32'h0, 32'h80FF7F01, 0, 0, a0);
        issue(0, 2'd0, 1, 32'h40, 32'h2, 32'h0, 1, 32'hFFFFFFFF, a0);
        issue(0, 2'd0, 0, 32'h40, 32'h2, 32'h0, 1, 32'h000000FF, a0);
        issue(0, 2'd1, 1, 32'h40, 32'h0, 32'h0, 1, 32'h00007F01, a0);

        // Half store into the upper lane of a word.
        issue(1, 2'd2, 0, 32'h1C, 32'h0, 32'hAAAA5555, 0, 0, a0);
        issue(1, 2'd1, 0, 32'h1E, 32'h0, 32'h00001234, 0, 0, a0);
        issue(0, 2'd2, 0, 32'h1C, 32'h0, 32'h0, 1, 32'h12345555, a0);

        // Misaligned word load and illegal doubleword size.
        issue(1, 2'd2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, a0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 2'd2, 0, 32'h1, 32'h2, 32'h0, 1, 32'h0, a0);
`else
        issue(0, 2'd2, 0, 32'h1, 32'h2, 32'h0, 1, 32'hCAFEF00D, a0);
`endif
        issue(0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 1, 32'h0, a0);
        issue(1, 2'd3, 0, 32'h8, 32'h0, 32'h12345678, 1, 32'h0, a0);

        // Back-to-back loads with request held: accepts spaced MEM_LAT+3 apart.
        issue(0, 2'd2, 0, 32'h100, 32'h4, 32'h0, 1, 32'hDEADBEEF, a1);
        issue(0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1, 32'h80FF7F01, a2);
        issue(0, 2'd0, 0, 32'h40, 32'h3, 32'h0, 1, 32'h00000080, a3);
        check("b2b_gap1", 64'(a2 - a1), 64'(MEM_LAT + 3));
        check("b2b_gap2", 64'(a3 - a2), 64'(MEM_LAT + 3));
        idle(6);

        // Reset while waiting on read data abandons the load.
        issue(1, 2'd2, 0, 32'h4, 32'h0, 32'h5A5A0001, 0, 0, a0);
        issue(0, 2'd2, 0, 32'h4, 32'h0, 32'h0, 0, 0, a0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {63'd0, req_ready}, 64'd1);
        idle(MEM_LAT + 2);

        // Effective-address wrap: 0xFFFFFFFF + 5 -> ea 4, word 1.
        issue(0, 2'd2, 0, 32'hFFFFFFFF, 32'h5, 32'h0, 1, 32'h5A5A0001, a0);

        // Randomised mix against the reference model.
        for (int k = 0; k < 150; k++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, 32'($urandom_range(0, 64)), $urandom, 0, 0, a0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        req_valid = 1'b0;

        budget = 0;
        while ((rsp_q.size() != 0 || stb_q.size() != 0) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        if (rsp_q.size() != 0 || stb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses and %0d strobes outstanding, required 0",
                     rsp_q.size(), stb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
